// File: rtl/serial_barrel_unshifter.sv
// rtl/serial_barrel_unshifter.sv - multi-cycle right rotator, one bit per clock
//
// Rotates i right by shift, one bit position per clock, and presents the
// result on a registered output. It undoes the matching left barrel rotator.
//
// Ports:
//   clk    in   clock; all state changes on its rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   begin a rotation (sampled only while idle)
//   i      in   WIDTH-bit word, captured when start is accepted
//   shift  in   SHW-bit right-rotate amount, captured with i
//   busy   out  high while a rotation is in progress or completing
//   done   out  one-cycle pulse when o has just been updated
//   o      out  WIDTH-bit registered result

module serial_barrel_unshifter #(
    parameter int WIDTH = 4,
    parameter int SHW   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] i,
    input  logic [SHW-1:0]   shift,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] o
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_reg_q, work_reg_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] o_q, o_d;

    always_comb begin
        state_d    = state_q;
        work_reg_d = work_reg_q;
        cnt_d      = cnt_q;
        o_d        = o_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    work_reg_d = i;
                    cnt_d      = shift;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    // Decrement only when non-zero, so cnt never wraps.
                    work_reg_d = {work_reg_q[0], work_reg_q[WIDTH-1:1]};
                    cnt_d      = cnt_q - SHW'(1);
                end else begin
                    o_d     = work_reg_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            work_reg_q <= '0;
            cnt_q      <= '0;
            o_q        <= '0;
        end else begin
            state_q    <= state_d;
            work_reg_q <= work_reg_d;
            cnt_q      <= cnt_d;
            o_q        <= o_d;
        end
    end

    // Status is a pure decode of the state flops: no path from the inputs.
    assign busy = (state_q == SHIFT) || (state_q == DONE);
    assign done = (state_q == DONE);
    assign o    = o_q;

endmodule

// File: tb/tb_serial_barrel_unshifter.sv
// tb/tb_serial_barrel_unshifter.sv - self-checking bench for serial_barrel_unshifter

module tb_serial_barrel_unshifter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] i;
    logic [1:0] shift;
    logic       busy;
    logic       done;
    logic [3:0] o;

    int total = 0;
    int bad   = 0;

    serial_barrel_unshifter #(.WIDTH(4), .SHW(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .i     (i),
        .shift (shift),
        .busy  (busy),
        .done  (done),
        .o     (o)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] ror(input logic [3:0] x, input int s);
        logic [7:0] d;
        d = {x, x} >> s;
        return d[3:0];
    endfunction

    function automatic logic [3:0] rol(input logic [3:0] x, input int s);
        logic [7:0] d;
        d = {x, x} << s;
        return d[7:4];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a request at a falling edge; returns at the falling edge after
    // the accepting rising edge, with start dropped.
    task automatic start_op(input logic [3:0] iv, input logic [1:0] sv);
        @(negedge clk);
        i     = iv;
        shift = sv;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        i     = 4'bxxxx;
        shift = 2'bxx;
    endtask

    // Entered at the falling edge after the accept edge. Counts edges from
    // accept (inclusive) to DONE entry and the number of busy cycles.
    task automatic wait_done(input string tag, input int sv, input logic [3:0] exp_o);
        int edges;
        int busy_cnt;
        edges    = 1;
        busy_cnt = 0;
        while (done !== 1'b1 && edges < 20) begin
            if (busy === 1'b1) busy_cnt++;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        if (busy === 1'b1) busy_cnt++;
        chk({tag, "_done_seen"}, done, 1'b1);
        chk({tag, "_latency"}, edges, sv + 2);
        chk({tag, "_busy_cycles"}, busy_cnt, sv + 2);
        chk({tag, "_o"}, o, exp_o);
    endtask

    task automatic full_op(input string tag, input logic [3:0] iv, input logic [1:0] sv,
                           input logic [3:0] exp_o);
        start_op(iv, sv);
        wait_done(tag, sv, exp_o);
        @(negedge clk);
        chk({tag, "_done_pulse_end"}, done, 1'b0);
        chk({tag, "_idle_after"}, busy, 1'b0);
        chk({tag, "_o_hold"}, o, exp_o);
    endtask

    initial begin
        logic [3:0] iv;
        logic [1:0] sv;
        logic [3:0] exp_o;
        bit         saw_done;

        rst_n = 1'b0;
        start = 1'b0;
        i     = 4'h0;
        shift = 2'h0;
        #12;
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_o", o, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 1'b0);

        // i=1000 shift=1: busy the cycle after accept
        start_op(4'b1000, 2'd1);
        chk("s1_busy_rise", busy, 1'b1);
        wait_done("s1", 1, 4'b0100);
        @(negedge clk);

        full_op("s2a", 4'b1001, 2'd3, 4'b0011);
        full_op("s2b", 4'b0110, 2'd2, 4'b1001);
        full_op("s3", 4'b0101, 2'd0, 4'b0101);

        // start held high with new operands during SHIFT is ignored
        start_op(4'b1100, 2'd3);
        start = 1'b1;
        i     = 4'b1111;
        shift = 2'd1;
        wait_done("s4", 3, 4'b1001);
        @(negedge clk);
        chk("s4_idle_gap", busy, 1'b0);
        chk("s4_o_hold", o, 4'b1001);
        @(negedge clk);
        chk("s4_reaccept", busy, 1'b1);
        start = 1'b0;
        wait_done("s4_next", 1, 4'b1111);
        @(negedge clk);

        // asynchronous reset mid-SHIFT
        start_op(4'b1010, 2'd3);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_o", o, 4'h0);
        saw_done = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        chk("rst_no_done", saw_done, 1'b0);
        rst_n = 1'b1;
        full_op("s5", 4'b0011, 2'd1, 4'b1001);

        // random operands against the rotate model, with random idle gaps
        for (int n = 0; n < 20; n++) begin
            iv    = 4'($urandom);
            sv    = 2'($urandom);
            exp_o = ror(iv, int'(sv));
            full_op("rand", iv, sv, exp_o);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // left-rotate then right-rotate by the same amount restores i
        for (int a = 0; a < 16; a++) begin
            for (int s = 0; s < 4; s++) begin
                iv = 4'(a);
                sv = 2'(s);
                full_op("roundtrip", rol(iv, s), sv, iv);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog timeout");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_barrel_unshifter.md
SERIAL_BARREL_UNSHIFTER -- requirements
Module: serial_barrel_unshifter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the data word width in bits.
REQ-002 The block SHALL have parameter SHW, default 2, giving the shift-amount width in bits; WIDTH SHALL be at least 2^SHW.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit: request to begin a rotation, sampled only in IDLE.
REQ-006 The block SHALL have port i, input, WIDTH bits: the word to rotate, captured when start is accepted.
REQ-007 The block SHALL have port shift, input, SHW bits: the right-rotate amount, captured with i.
REQ-008 The block SHALL have port busy, output, 1 bit: high while in SHIFT or DONE.
REQ-009 The block SHALL have port done, output, 1 bit: a one-cycle pulse, high only in DONE.
REQ-010 The block SHALL have port o, output, WIDTH bits: the registered result, i rotated right by shift.

Function
REQ-011 The block SHALL be the inverse of the team's 4-bit left barrel rotator: left-rotating i by s and then right-rotating the result by s here SHALL return i.
REQ-012 The FSM SHALL have three states, IDLE, SHIFT and DONE, encoded as 2-bit state with IDLE = 00.
REQ-013 IDLE: when start = 1 at a rising edge, the block SHALL load work_reg <= i and cnt <= shift, then go to SHIFT; when start = 0 it SHALL stay in IDLE.
REQ-014 SHIFT with cnt != 0: at each edge the block SHALL set work_reg <= {work_reg[0], work_reg[WIDTH-1:1]}, set cnt <= cnt - 1, and stay in SHIFT.
REQ-015 SHIFT with cnt == 0: at the edge the block SHALL set o <= work_reg, leave work_reg unrotated, and go to DONE.
REQ-016 DONE: the block SHALL hold done = 1 for exactly one cycle, then go to IDLE at the next edge unconditionally.
REQ-017 Latency SHALL be shift + 2 edges from the start-accept edge to the DONE-entry edge; done SHALL be high during the cycle after that edge.
- Example: shift = 0 gives done one cycle after the accept cycle.
REQ-018 start SHALL be ignored in SHIFT and DONE; i and shift SHALL be don't-care outside the accept edge.
REQ-019 Back-to-back operations SHALL require at least one IDLE cycle; a start that is high continuously SHALL be accepted on the first IDLE edge after DONE.
REQ-020 o SHALL change only on the DONE-entry edge and SHALL otherwise hold its last result.
REQ-021 The cnt register SHALL be SHW bits wide; the decrement SHALL never wrap, because it occurs only when cnt != 0.
REQ-022 busy and done SHALL be decoded directly from state registers, with no combinational path from the inputs.

Reset
REQ-023 When rst_n = 0, the block SHALL immediately, without waiting for a clock edge, force state = IDLE, work_reg = 0, cnt = 0, o = 0, busy = 0 and done = 0.
REQ-024 Reset asserted mid-operation SHALL abort the operation, with no done pulse and o = 0.
REQ-025 After rst_n deasserts, the first accepted start SHALL behave exactly as from power-up.

Verification
REQ-026 Scenario: i=1000, shift=01, start one cycle.
- Required: busy rises the next cycle; done pulses 3 edges after accept; o=0100.
REQ-027 Scenario: i=1001, shift=11.
- Required: o=0011 with done 5 edges after accept.
- Then i=0110, shift=10 → o=1001.
REQ-028 Scenario: i=0101, shift=00.
- Required: o=0101, done 2 edges after accept, busy high for exactly 2 cycles.
REQ-029 Scenario: during SHIFT for i=1100, shift=11, drive start=1, i=1111, shift=01.
- Required: the change is ignored; o=1001; the next start is accepted only after done.
REQ-030 Scenario: assert rst_n=0 between clock edges while in SHIFT.
- Required: busy, done and o go to 0 immediately; no done pulse; after release, i=0011, shift=01 → o=1001.
REQ-031 Round-trip sweep: for all 16 values of i and all 4 shifts, feed the left-rotator output in here.
- Required: o equals the original i in every case.
